// File: rtl/sprite_pkg.sv
// sprite_pkg: shared encodings for the sprite attribute unit.
//   - field_e : attribute byte select (X, Y, IMG, CTRL)
//   - state_e : request FSM states
//   - op_e    : latched request kind (write, read, read-modify-write add)
//   - req_t   : request captured on acceptance
//   - get_field / field_mask : byte extraction and byte-enable helpers
package sprite_pkg;

    localparam int SPRITE_COUNT = 256;
    localparam int FIELD_W      = 8;
    localparam int FIELD_COUNT  = 4;
    localparam int ADDR_W       = $clog2(SPRITE_COUNT);
    localparam int WORD_W       = FIELD_COUNT * FIELD_W;

    typedef enum logic [1:0] {
        FIELD_X    = 2'd0,
        FIELD_Y    = 2'd1,
        FIELD_IMG  = 2'd2,
        FIELD_CTRL = 2'd3
    } field_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MOD  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_WR  = 2'd0,
        OP_RD  = 2'd1,
        OP_RMW = 2'd2
    } op_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        field_e             field;
        logic [FIELD_W-1:0] wdata;
        op_e                op;
    } req_t;

    // Pick one attribute byte out of a packed {CTRL,IMG,Y,X} word.
    function automatic logic [FIELD_W-1:0] get_field(input logic [WORD_W-1:0] word,
                                                     input field_e field);
        logic [FIELD_W-1:0] b;
        case (field)
            FIELD_X:    b = word[7:0];
            FIELD_Y:    b = word[15:8];
            FIELD_IMG:  b = word[23:16];
            default:    b = word[31:24];
        endcase
        return b;
    endfunction

    // One-hot byte enable for the selected attribute.
    function automatic logic [FIELD_COUNT-1:0] field_mask(input field_e field);
        return 4'b0001 << field;
    endfunction

endpackage

// File: rtl/sprite_if.sv
// sprite_if: request/response bus between the EX stage and the sprite unit.
//   master (EX)          drives sprite_re, sprite_we, sprite_action, sprite_addr, sprite_wdata
//   slave (sprite_unit)  drives sprite_busy, sprite_data, sprite_data_valid
interface sprite_if;
    import sprite_pkg::*;

    logic               sprite_re;
    logic               sprite_we;
    logic [3:0]         sprite_action;
    logic [ADDR_W-1:0]  sprite_addr;
    logic [FIELD_W-1:0] sprite_wdata;
    logic               sprite_busy;
    logic [WORD_W-1:0]  sprite_data;
    logic               sprite_data_valid;

    modport master (
        output sprite_re, sprite_we, sprite_action, sprite_addr, sprite_wdata,
        input  sprite_busy, sprite_data, sprite_data_valid
    );

    modport slave (
        input  sprite_re, sprite_we, sprite_action, sprite_addr, sprite_wdata,
        output sprite_busy, sprite_data, sprite_data_valid
    );

endinterface

// File: rtl/sprite_ram.sv
// sprite_ram: 256 x 32 attribute storage, one word per sprite {CTRL,IMG,Y,X}.
//   clk, rst         clock; rst clears only the display output register
//   a_addr/a_we/a_wdata/a_rdata  port A: synchronous read, per-byte write
//   b_addr/b_rdata   port B: synchronous read-only (renderer)
// Both ports read the contents as they were before the edge, so a same-edge
// write is seen one cycle later (read-before-write).
module sprite_ram
    import sprite_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [FIELD_COUNT-1:0] a_we,
    input  logic [WORD_W-1:0]      a_wdata,
    output logic [WORD_W-1:0]      a_rdata,
    input  logic [ADDR_W-1:0]      b_addr,
    output logic [WORD_W-1:0]      b_rdata
);

    logic [WORD_W-1:0] mem [SPRITE_COUNT];

    // NOTE: the array has no reset; attribute contents must survive rst and a
    // resettable array would not map onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIELD_COUNT; i++) begin
            if (a_we[i]) begin
                // NOTE: non-blocking writes keep reads in this edge on old data.
                mem[a_addr][FIELD_W*i +: FIELD_W] <= a_wdata[FIELD_W*i +: FIELD_W];
            end
        end
        a_rdata <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_rdata <= '0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sprite_unit.sv
// sprite_unit: sprite attribute unit serving EX read / write / read-modify-write
// requests and a never-stalling renderer display port.
//   clk, rst    clock and synchronous active-high reset
//   bus         sprite_if.slave request/response bus
//   disp_addr   renderer sprite index
//   disp_attr   {CTRL,IMG,Y,X} of disp_addr from the previous edge
module sprite_unit
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sprite_if.slave           bus,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [WORD_W-1:0] disp_attr
);

    state_e                 state, next_state;
    req_t                   req_q;
    logic [FIELD_W-1:0]     sum_q;
    logic [WORD_W-1:0]      data_q;
    logic                   valid_q;
    logic [WORD_W-1:0]      ram_rdata;
    logic [FIELD_COUNT-1:0] ram_we;
    logic [FIELD_W-1:0]     wr_byte;
    logic                   req_strobe;
    logic                   unused_action;

    assign req_strobe    = bus.sprite_re | bus.sprite_we;
    assign unused_action = ^bus.sprite_action[3:2];

    assign bus.sprite_busy       = (state != S_IDLE);
    assign bus.sprite_data       = data_q;
    assign bus.sprite_data_valid = valid_q;

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        next_state = state;
        ram_we     = '0;
        wr_byte    = (req_q.op == OP_RMW) ? sum_q : req_q.wdata;
        case (state)
            S_IDLE: if (req_strobe) next_state = bus.sprite_re ? S_RD : S_WR;
            S_RD:   next_state = (req_q.op == OP_RMW) ? S_MOD : S_RESP;
            S_MOD:  next_state = S_WR;
            S_WR: begin
                next_state = S_IDLE;
                // Gated by rst so an aborted operation never commits its write.
                if (!rst) ram_we = field_mask(req_q.field);
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            req_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= next_state;
            valid_q <= 1'b0;
            if (state == S_IDLE && req_strobe) begin
                req_q <= '{addr:  bus.sprite_addr,
                           field: field_e'(bus.sprite_action[1:0]),
                           wdata: bus.sprite_wdata,
                           op:    bus.sprite_re ? (bus.sprite_we ? OP_RMW : OP_RD) : OP_WR};
            end
            // Port A data read at the RD edge is available in MOD / RESP.
            if (state == S_MOD) begin
                sum_q <= get_field(ram_rdata, req_q.field) + req_q.wdata;
            end
            if (state == S_RESP) begin
                data_q  <= WORD_W'(get_field(ram_rdata, req_q.field));
                valid_q <= 1'b1;
            end
            if (state == S_WR && req_q.op == OP_RMW) begin
                data_q  <= WORD_W'(sum_q);
                valid_q <= 1'b1;
            end
        end
    end

    sprite_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (req_q.addr),
        .a_we    (ram_we),
        .a_wdata ({FIELD_COUNT{wr_byte}}),
        .a_rdata (ram_rdata),
        .b_addr  (disp_addr),
        .b_rdata (disp_attr)
    );

endmodule

// File: tb/tb_sprite_unit.sv
// tb_sprite_unit: self-checking bench for sprite_unit. A byte-array model of the
// attribute table predicts read/RMW results, busy length, valid timing and
// display words; random and directed scenarios are compared against it.
module tb_sprite_unit;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  disp_addr = '0;
    logic [31:0] disp_attr;

    sprite_if bus();

    sprite_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .disp_addr (disp_addr),
        .disp_attr (disp_attr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [256][4];

    function automatic logic [31:0] model_word(input int a);
        return {model_mem[a][3], model_mem[a][2], model_mem[a][1], model_mem[a][0]};
    endfunction

    // Reference behaviour: write stores, read returns, RMW adds modulo 256.
    task automatic model_apply(input logic re, input logic we, input int fld, input int a,
                               input logic [7:0] wd, output int exp_busy, output int exp_idx,
                               output logic [31:0] exp_data);
        int sum;
        exp_data = '0;
        if (re && we) begin
            sum = int'(model_mem[a][fld]) + int'(wd);
            model_mem[a][fld] = 8'(sum % 256);
            exp_data = 32'(sum % 256);
            exp_busy = 3; exp_idx = 3;
        end else if (re) begin
            exp_data = 32'(model_mem[a][fld]);
            exp_busy = 2; exp_idx = 2;
        end else begin
            model_mem[a][fld] = wd;
            exp_busy = 1; exp_idx = -1;
        end
    endtask

    // Issue one request (called #1 after a rising edge, unit idle) and watch six
    // cycles after acceptance. Index i = cycle following edge k+i.
    task automatic run_req(input logic re, input logic we, input logic [1:0] fld,
                           input logic [7:0] addr, input logic [7:0] wd, input bit noise,
                           output int busy_n, output int valid_n, output int valid_idx,
                           output logic [31:0] data);
        busy_n = 0; valid_n = 0; valid_idx = -1; data = '0;
        bus.sprite_re     = re;
        bus.sprite_we     = we;
        bus.sprite_action = {2'($urandom), fld};
        bus.sprite_addr   = addr;
        bus.sprite_wdata  = wd;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (noise && i < 2) begin
                bus.sprite_addr   = addr ^ 8'(i + 1);
                bus.sprite_action = 4'($urandom);
                bus.sprite_wdata  = ~model_mem[addr ^ 8'(i + 1)][bus.sprite_action[1:0]];
                bus.sprite_re     = (i == 0);
                bus.sprite_we     = 1'b1;
            end else begin
                bus.sprite_re = 1'b0;
                bus.sprite_we = 1'b0;
            end
            if (bus.sprite_busy) busy_n++;
            if (bus.sprite_data_valid) begin
                valid_n++;
                if (valid_idx < 0) begin
                    valid_idx = i;
                    data = bus.sprite_data;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic disp_read(input logic [7:0] a, output logic [31:0] w);
        disp_addr = a;
        @(posedge clk); #1;
        w = disp_attr;
    endtask

    task automatic test_reset();
        bus.sprite_re = 1'b0; bus.sprite_we = 1'b0; bus.sprite_action = '0;
        bus.sprite_addr = '0; bus.sprite_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.sprite_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.sprite_busy); end
        checks++; if (bus.sprite_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.sprite_data_valid); end
        checks++; if (bus.sprite_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.sprite_data); end
        checks++; if (disp_attr !== 32'h0) begin errors++; $display("FAIL reset_disp: got %h want 0", disp_attr); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.sprite_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", bus.sprite_busy); end
    endtask

    // Back-to-back writes of every field of every sprite (CTRL = index), then a
    // full display sweep changing disp_addr every cycle.
    task automatic test_fill_sweep();
        logic [7:0] wd;
        for (int a = 0; a < 256; a++) begin
            for (int f = 0; f < 4; f++) begin
                wd = (f == 3) ? 8'(a) : 8'($urandom);
                bus.sprite_re = 1'b0; bus.sprite_we = 1'b1;
                bus.sprite_action = 4'(f); bus.sprite_addr = 8'(a); bus.sprite_wdata = wd;
                @(posedge clk); #1;
                checks++; if (bus.sprite_busy !== 1'b1) begin errors++; $display("FAIL fill_busy a=%0d f=%0d: got %b want 1", a, f, bus.sprite_busy); end
                model_mem[a][f] = wd;
                @(posedge clk); #1;
                checks++; if ({bus.sprite_busy, bus.sprite_data_valid} !== 2'b00) begin errors++; $display("FAIL fill_idle a=%0d f=%0d: got busy/valid %b want 00", a, f, {bus.sprite_busy, bus.sprite_data_valid}); end
            end
        end
        bus.sprite_we = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) begin
                checks++;
                if (disp_attr !== model_word(i - 1)) begin errors++; $display("FAIL sweep sprite %0d: got %h want %h", i - 1, disp_attr, model_word(i - 1)); end
            end
            if (i < 256) disp_addr = 8'(i);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read();
        int b, v, idx, eb, ei; logic [31:0] d, ed;
        model_apply(1'b0, 1'b1, 0, 5, 8'h40, eb, ei, ed);
        run_req(1'b0, 1'b1, FIELD_X, 8'd5, 8'h40, 1'b0, b, v, idx, d);
        checks++; if (b !== 1) begin errors++; $display("FAIL wr_busy_cycles: got %0d want 1", b); end
        checks++; if (v !== 0) begin errors++; $display("FAIL wr_no_valid: got %0d want 0", v); end
        model_apply(1'b1, 1'b0, 0, 5, 8'h00, eb, ei, ed);
        run_req(1'b1, 1'b0, FIELD_X, 8'd5, 8'h00, 1'b0, b, v, idx, d);
        checks++; if (b !== 2) begin errors++; $display("FAIL rd_busy_cycles: got %0d want 2", b); end
        checks++; if (v !== 1 || idx !== 2) begin errors++; $display("FAIL rd_valid: got count %0d at %0d want 1 at 2", v, idx); end
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL rd_data: got %h want 00000040", d); end
        checks++; if (bus.sprite_data !== 32'h40 || bus.sprite_data_valid !== 1'b0) begin errors++; $display("FAIL data_hold: got %h/%b want 00000040/0", bus.sprite_data, bus.sprite_data_valid); end
    endtask

    task automatic test_rmw_wrap();
        int b, v, idx, eb, ei; logic [31:0] d, ed, w;
        model_apply(1'b0, 1'b1, 2, 9, 8'hFF, eb, ei, ed);
        run_req(1'b0, 1'b1, FIELD_IMG, 8'd9, 8'hFF, 1'b0, b, v, idx, d);
        model_apply(1'b1, 1'b1, 2, 9, 8'h02, eb, ei, ed);
        run_req(1'b1, 1'b1, FIELD_IMG, 8'd9, 8'h02, 1'b0, b, v, idx, d);
        checks++; if (b !== 3) begin errors++; $display("FAIL rmw_busy_cycles: got %0d want 3", b); end
        checks++; if (v !== 1 || idx !== 3) begin errors++; $display("FAIL rmw_valid: got count %0d at %0d want 1 at 3", v, idx); end
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL rmw_wrap_data: got %h want 00000001", d); end
        disp_read(8'd9, w);
        checks++; if (w !== model_word(9) || w[23:16] !== 8'h01) begin errors++; $display("FAIL rmw_disp: got %h want %h", w, model_word(9)); end
    endtask

    task automatic test_read_before_write();
        logic [31:0] old_w;
        disp_addr = 8'd3;
        @(posedge clk); #1;
        old_w = model_word(3);
        bus.sprite_re = 1'b0; bus.sprite_we = 1'b1; bus.sprite_action = 4'd1;
        bus.sprite_addr = 8'd3; bus.sprite_wdata = 8'h11;
        @(posedge clk); #1;
        bus.sprite_we = 1'b0;
        model_mem[3][1] = 8'h11;
        @(posedge clk); #1;
        checks++; if (disp_attr !== old_w) begin errors++; $display("FAIL rbw_old: got %h want %h", disp_attr, old_w); end
        @(posedge clk); #1;
        checks++; if (disp_attr !== model_word(3)) begin errors++; $display("FAIL rbw_new: got %h want %h", disp_attr, model_word(3)); end
    endtask

    task automatic test_ignore_while_busy();
        int b, v, idx, eb, ei; logic [31:0] d, ed, w;
        model_apply(1'b1, 1'b0, 1, 20, 8'h00, eb, ei, ed);
        run_req(1'b1, 1'b0, FIELD_Y, 8'd20, 8'h00, 1'b1, b, v, idx, d);
        checks++; if (v !== 1 || idx !== 2) begin errors++; $display("FAIL ignore_valid: got count %0d at %0d want 1 at 2", v, idx); end
        checks++; if (d !== ed) begin errors++; $display("FAIL ignore_data: got %h want %h", d, ed); end
        for (int n = 20; n <= 23; n++) begin
            disp_read(8'(n), w);
            checks++; if (w !== model_word(n)) begin errors++; $display("FAIL ignore_no_write sprite %0d: got %h want %h", n, w, model_word(n)); end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int b, v, idx, eb, ei, pulses; logic [31:0] d, ed;
        bus.sprite_re = 1'b1; bus.sprite_we = 1'b1; bus.sprite_action = 4'd2;
        bus.sprite_addr = 8'd9; bus.sprite_wdata = 8'h10;
        @(posedge clk); #1;
        bus.sprite_re = 1'b0; bus.sprite_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.sprite_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.sprite_busy); end
        checks++; if (bus.sprite_data !== 32'h0 || disp_attr !== 32'h0) begin errors++; $display("FAIL abort_clear: got data %h disp %h want 0 0", bus.sprite_data, disp_attr); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.sprite_data_valid) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_valid: got %0d pulses want 0", pulses); end
        model_apply(1'b1, 1'b0, 2, 9, 8'h00, eb, ei, ed);
        run_req(1'b1, 1'b0, FIELD_IMG, 8'd9, 8'h00, 1'b0, b, v, idx, d);
        checks++; if (d !== 32'h01 || d !== ed) begin errors++; $display("FAIL abort_ram_kept: got %h want %h", d, ed); end
    endtask

    task automatic test_reset_priority();
        logic [31:0] w;
        bus.sprite_re = 1'b0; bus.sprite_we = 1'b1; bus.sprite_action = 4'd0;
        bus.sprite_addr = 8'd77; bus.sprite_wdata = ~model_mem[77][0];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.sprite_we = 1'b0;
        checks++; if (bus.sprite_busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy: got %b want 0", bus.sprite_busy); end
        @(posedge clk); #1;
        disp_read(8'd77, w);
        checks++; if (w !== model_word(77)) begin errors++; $display("FAIL rst_prio_no_write: got %h want %h", w, model_word(77)); end
    endtask

    task automatic test_random_ops();
        int b, v, idx, eb, ei, sel, fld, a; logic re, we; logic [7:0] wd; logic [31:0] d, ed;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 2);
            re = (sel != 0); we = (sel != 1);
            fld = $urandom_range(0, 3); a = $urandom_range(0, 255); wd = 8'($urandom);
            model_apply(re, we, fld, a, wd, eb, ei, ed);
            run_req(re, we, 2'(fld), 8'(a), wd, 1'b0, b, v, idx, d);
            checks++; if (b !== eb) begin errors++; $display("FAIL rand_busy #%0d op=%0d: got %0d want %0d", n, sel, b, eb); end
            checks++; if (idx !== ei || v !== (ei < 0 ? 0 : 1)) begin errors++; $display("FAIL rand_valid #%0d op=%0d: got count %0d at %0d want at %0d", n, sel, v, idx, ei); end
            if (ei >= 0) begin
                checks++; if (d !== ed) begin errors++; $display("FAIL rand_data #%0d op=%0d: got %h want %h", n, sel, d, ed); end
            end
        end
    endtask

    task automatic test_display_random();
        logic [7:0] prev;
        prev = 8'($urandom);
        disp_addr = prev;
        @(posedge clk); #1;
        for (int n = 0; n < 200; n++) begin
            checks++; if (disp_attr !== model_word(prev)) begin errors++; $display("FAIL disp_rand sprite %0d: got %h want %h", prev, disp_attr, model_word(prev)); end
            prev = 8'($urandom);
            disp_addr = prev;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_fill_sweep();
        test_write_read();
        test_rmw_wrap();
        test_read_before_write();
        test_ignore_while_busy();
        test_reset_mid_rmw();
        test_reset_priority();
        test_random_ops();
        test_display_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_unit.md
SPRITE_UNIT -- requirements
Module: sprite_unit

Interface
REQ-001 SHALL have no parameters; sprite count fixed at 256, four 8-bit attribute fields per sprite.
REQ-002 SHALL have a single clock and a synchronous, active-high reset; ports as below.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sprite_re  in  1  read strobe from EX.
REQ-006 sprite_we  in  1  write strobe from EX; re and we both high means read-modify-write add.
REQ-007 sprite_action  in  4  [1:0] field select (0 X, 1 Y, 2 IMG, 3 CTRL); [3:2] ignored.
REQ-008 sprite_addr  in  8  sprite index.
REQ-009 sprite_wdata  in  8  write data or addend (EX has already resolved immediate vs register).
REQ-010 sprite_busy  out  1  high while a request is in progress; EX stalls and holds the request.
REQ-011 sprite_data  out  32  read/RMW result, zero-extended from 8 bits.
REQ-012 sprite_data_valid  out  1  one-cycle qualifier for sprite_data.
REQ-013 disp_addr  in  8  renderer read index.
REQ-014 disp_attr  out  32  {CTRL,IMG,Y,X} of disp_addr sampled on the previous edge.

Function
REQ-015 FSM states SHALL be IDLE, RD, MOD, WR, RESP.
REQ-016 Requests SHALL be sampled only in IDLE; any strobe in other states is ignored.
REQ-017 The request SHALL be latched on acceptance edge k (addr, field, wdata, op).
REQ-018 Write {we=1,re=0}: IDLE->WR; byte written at edge k+1; busy high for cycle k..k+1 only; no valid pulse.
REQ-019 Read {we=0,re=1}: IDLE->RD->RESP->IDLE; sprite_data_valid high for exactly the cycle following edge k+2.
REQ-020 RMW {we=1,re=1}: IDLE->RD->MOD->WR->IDLE; new = old + wdata, 8-bit wrap-around, no saturation or flags.
REQ-021 RMW: new value written at edge k+3; sprite_data = new value with valid high for the cycle following edge k+3.
REQ-022 sprite_busy SHALL be high whenever state != IDLE, combinationally derived from state.
REQ-023 sprite_data SHALL hold its last value when valid is low.
REQ-024 The display port SHALL have fixed 1-cycle latency and never stall, independent of the FSM.
REQ-025 On a same-edge display read and CPU write to the same sprite, display SHALL return the old data (read-before-write).
REQ-026 A write SHALL modify only the selected byte; the other three fields are unchanged.

Reset
REQ-027 Reset SHALL force state IDLE, sprite_busy 0, sprite_data_valid 0, sprite_data 0, disp_attr 0.
REQ-028 Reset mid-operation SHALL abort; any write not yet performed SHALL not occur.
REQ-029 Reset SHALL NOT clear attribute RAM contents.
REQ-030 Reset has priority over a request on the same edge.

Structure
REQ-031 sprite_pkg SHALL hold the field encodings, state encoding, 256 sprite count and 8-bit field width.
REQ-032 Storage SHALL be sub-module sprite_ram: 256x32, port A read/byte-write, port B read-only, both synchronous.
REQ-033 No combinational path SHALL exist from request inputs to sprite_data.

Verification
REQ-034 Write X=8'h40 to sprite 5, then read X of sprite 5 -> valid pulse at k+2, sprite_data=32'h40; busy 1 cycle on the write, 2 cycles on the read.
REQ-035 IMG=8'hFF at sprite 9; RMW IMG +8'h02 -> sprite_data=32'h01; display read of sprite 9 then shows IMG=01, other bytes unchanged.
REQ-036 Write Y=8'h11 to sprite 3 with disp_addr=3 on the write edge -> disp_attr shows old Y that cycle, 8'h11 the next.
REQ-037 Issue a read, then toggle re/we with different addr during busy -> ignored; exactly one valid pulse and no extra RAM write.
REQ-038 Assert rst during RMW state MOD -> next cycle IDLE, busy=0, valid never pulses, RAM byte retains its old value.
REQ-039 Back-to-back writes to sprites 0..255 (CTRL=index) then a display sweep -> disp_attr[31:24]=index for every sprite, no stalls on the display port.
